fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Pointer/flag controller that sequences the dual-address buffer memory
//  (MEM_LENGTH x BUS_SIZE, registered read) as a circular FIFO.
//  Converts push/pop requests into write/read strobes and addresses.
//  Produces occupancy count, full/empty and programmable almost-full/almost-empty flags.
//  Sits between the upstream producer / downstream consumer and the memory instance.
// PARAMETERS
//  ADDR_WIDTH  3                  memory address width; must match the memory instance
//  MEM_LENGTH  1<<ADDR_WIDTH (8)  FIFO depth in entries
//  CNT_WIDTH   ADDR_WIDTH+1       occupancy counter width (counts 0..MEM_LENGTH)
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           synchronous, active-high reset
//  push          in   1           producer request to write one entry this cycle
//  pop           in   1           consumer request to read one entry this cycle
//  umbral_af     in   CNT_WIDTH   almost-full threshold; sampled only while reset=1
//  umbral_ae     in   CNT_WIDTH   almost-empty threshold; sampled only while reset=1
//  write         out  1           memory write strobe (combinational: push accepted)
//  read          out  1           memory read strobe (combinational: pop accepted)
//  addressW      out  ADDR_WIDTH  memory write address = wr_ptr
//  addressR      out  ADDR_WIDTH  memory read address = rd_ptr
//  valid_out     out  1           registered; memory data_out holds popped word this cycle
//  count         out  CNT_WIDTH   registered occupancy
//  full          out  1           count == MEM_LENGTH
//  empty         out  1           count == 0
//  almost_full   out  1           count >= umbral_af (registered threshold)
//  almost_empty  out  1           count <= umbral_ae (registered threshold)
//  overflow      out  1           sticky; push refused while full (ERR feature only)
//  underflow     out  1           sticky; pop refused while empty (ERR feature only)
// BEHAVIOUR
//  - Reset (synchronous, active-high): wr_ptr=rd_ptr=0, count=0, valid_out=0,
//    overflow=underflow=0; umbral_af/umbral_ae captured into internal registers.
//  - Flags out of reset: empty=1, full=0, almost_empty=1 (0<=umbral_ae),
//    almost_full=(umbral_af==0).
//  - While reset=1, write=read=0 regardless of push/pop.
//  - Accept rules:
//      push_ok = push & (~full | pop)
//      pop_ok  = pop & ~empty
//      write = push_ok, read = pop_ok.
//  - Full with push&pop: both accepted. The same-address read returns the old
//    (oldest) word, since the memory read is registered.
//  - Empty with push&pop: push accepted, pop refused. No bypass path.
//  - Pointer update on each accepted op: ptr <= ptr+1. Natural ADDR_WIDTH
//    wrap-around (7 -> 0 when ADDR_WIDTH=3).
//  - count next value:
//      +1 on push_ok only
//      -1 on pop_ok only
//      unchanged on both or neither.
//    count never exceeds MEM_LENGTH and never underflows.
//  - Status flags (full, empty, almost_*) are combinational from registered count;
//    they update the cycle after the op.
//  - Read latency: valid_out <= pop_ok. Popped data is on memory data_out exactly
//    1 cycle after read=1; valid_out is high in that same cycle.
//  - Refused requests: pointers and count do not change; no strobe issued.
//  - Reset asserted mid-operation: all in-flight state is discarded;
//    valid_out=0 on the next edge. Memory contents are not cleared.
//  - Threshold ports are ignored outside reset; changing them requires a reset.
// CONFIGURATION
//  - Feature macro: FIFO_CTRL_ERR_EN.
//  - FIFO_CTRL_ERR_EN defined:
//      overflow  <= 1 when push & full & ~pop
//      underflow <= 1 when pop & empty
//      both are sticky until reset.
//  - FIFO_CTRL_ERR_EN undefined: overflow and underflow are tied to 0; no error
//    registers are built. The ports remain, so the interface is identical in both builds.
// TESTING  (ADDR_WIDTH=3, umbral_af=6, umbral_ae=1)
//  1. Reset, then 8 pushes with no pops:
//     -> addressW 0..7; count 1..8; almost_full rises when count=6; full=1 after the 8th push.
//  2. Full, push=1 and pop=0:
//     -> write=0, count stays 8, pointers unchanged.
//     -> overflow=1 with FIFO_CTRL_ERR_EN, 0 without.
//  3. From full, 8 pops:
//     -> addressR 0..7; valid_out 1 cycle after each read; empty=1 after the 8th pop.
//     -> A 9th pop gives read=0; underflow=1 with FIFO_CTRL_ERR_EN.
//  4. Wrap-around: 5 pushes, 5 pops, then 6 pushes:
//     -> addressW sequence 5,6,7,0,1,2; count=6; almost_full=1.
//  5. Empty, push&pop same cycle:
//     -> write=1, read=0, count=1.
//     -> From full, push&pop: write=1, read=1, count stays 8, old word read out.
//  6. Reset pulse mid-stream (count=4, pop active):
//     -> next cycle count=0, empty=1, valid_out=0, addresses 0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Circular-FIFO pointer/flag controller for a dual-address, registered-read buffer memory.
// Optional sticky overflow/underflow error flags are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int MEM_LENGTH = 1 << ADDR_WIDTH,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [CNT_WIDTH-1:0]  umbral_af,
  input  logic [CNT_WIDTH-1:0]  umbral_ae,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] addressW,
  output logic [ADDR_WIDTH-1:0] addressR,
  output logic                  valid_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  af_th;
  logic [CNT_WIDTH-1:0]  ae_th;
  logic                  push_ok;
  logic                  pop_ok;

  assign full         = (count == CNT_WIDTH'(MEM_LENGTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_th);
  assign almost_empty = (count <= ae_th);

  // A push into a full FIFO is still taken when a pop frees the slot the same cycle;
  // the registered memory read returns the old word before it is overwritten.
  assign push_ok = ~reset & push & (~full | pop);
  assign pop_ok  = ~reset & pop & ~empty;

  assign write    = push_ok;
  assign read     = pop_ok;
  assign addressW = wr_ptr;
  assign addressR = rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      af_th     <= umbral_af;
      ae_th     <= umbral_ae;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pop) overflow  <= 1'b1;
      if (pop & empty)        underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus random push/pop/reset traffic against a
// queue-based FIFO model, with a small registered-read memory to check popped data.
module tb_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic          clk = 1'b0;
  logic          reset, push, pop;
  logic [CW-1:0] umbral_af, umbral_ae;
  logic          write, read, valid_out, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [AW-1:0] addressW, addressR;
  logic [CW-1:0] count;

  logic [7:0] mem [DEPTH];
  logic [7:0] din;
  logic [7:0] data_out;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0] q[$];
  int  wr_n, rd_n, af_m, ae_m;
  bit  exp_valid, ovf_m, unf_m, started;
  logic [7:0] exp_data;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .umbral_af(umbral_af), .umbral_ae(umbral_ae),
    .write(write), .read(read), .addressW(addressW), .addressR(addressR),
    .valid_out(valid_out), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) mem[addressW] <= din;
    if (read)  data_out <= mem[addressR];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit p, input bit o);
    bit m_full, m_empty, push_ok, pop_ok;
    @(negedge clk);
    reset = r; push = p; pop = o; din = 8'($urandom);
    #1;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    push_ok = !r && p && (!m_full || o);
    pop_ok  = !r && o && !m_empty;
    if (started) begin
      check("write",        32'(write),        32'(push_ok));
      check("read",         32'(read),         32'(pop_ok));
      check("addressW",     32'(addressW),     32'(wr_n % DEPTH));
      check("addressR",     32'(addressR),     32'(rd_n % DEPTH));
      check("count",        32'(count),        32'(q.size()));
      check("full",         32'(full),         32'(m_full));
      check("empty",        32'(empty),        32'(m_empty));
      check("almost_full",  32'(almost_full),  32'(q.size() >= af_m));
      check("almost_empty", 32'(almost_empty), 32'(q.size() <= ae_m));
      check("valid_out",    32'(valid_out),    32'(exp_valid));
      check("overflow",     32'(overflow),     32'(ovf_m));
      check("underflow",    32'(underflow),    32'(unf_m));
      if (exp_valid) check("data_out", 32'(data_out), 32'(exp_data));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      wr_n = 0; rd_n = 0;
      af_m = int'(umbral_af); ae_m = int'(umbral_ae);
      exp_valid = 0; ovf_m = 0; unf_m = 0; started = 1;
    end else begin
      if (pop_ok) begin
        exp_data = q.pop_front();
        rd_n++;
      end
      if (push_ok) begin
        q.push_back(din);
        wr_n++;
      end
      exp_valid = pop_ok;
`ifdef FIFO_CTRL_ERR_EN
      if (p && m_full && !o) ovf_m = 1;
      if (o && m_empty)      unf_m = 1;
`endif
    end
  endtask

  initial begin
    started = 0; exp_valid = 0; ovf_m = 0; unf_m = 0;
    reset = 1; push = 0; pop = 0; din = '0;
    umbral_af = 4'd6; umbral_ae = 4'd1;

    cycle(1, 0, 0);
    cycle(1, 1, 1);
    repeat (8) cycle(0, 1, 0);             // fill
    repeat (2) cycle(0, 1, 0);             // push while full
    repeat (8) cycle(0, 0, 1);             // drain
    repeat (2) cycle(0, 0, 1);             // pop while empty
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (5) cycle(0, 1, 0);
    repeat (5) cycle(0, 0, 1);
    repeat (6) cycle(0, 1, 0);             // write pointer wraps 7 -> 0
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 1);                        // empty push&pop
    repeat (7) cycle(0, 1, 0);
    repeat (3) cycle(0, 1, 1);             // full push&pop
    repeat (4) cycle(0, 0, 1);
    cycle(1, 0, 1);                        // reset mid-stream with pop active
    cycle(0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      if (r) begin
        umbral_af = 4'($urandom_range(0, DEPTH));
        umbral_ae = 4'($urandom_range(0, DEPTH));
      end
      cycle(r, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50);
    end
    cycle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
